tdm_tx: RTL and testbench



---
 rtl/i2s_tdm_pkg.sv | 19 +
 rtl/tdm_clkgen.sv | 36 +++
 rtl/tdm_tx.sv | 124 ++++++++++++
 tb/tb_tdm_tx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_tdm_pkg.sv
// Shared constants and elaboration helpers for the I2S-to-TDM path.
package i2s_tdm_pkg;

  // Default sample width per channel
  localparam int unsigned DEF_BITS = 16;

  // Counter width for a 0..n-1 range, never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Master-clock cycles in one TDM frame
  function automatic int unsigned frame_cycles(input int unsigned slots,
                                               input int unsigned slot_bits,
                                               input int unsigned sclk_div);
    return slots * slot_bits * sclk_div;
  endfunction

endpackage

// File: rtl/tdm_clkgen.sv
// Bit-clock generator: divides mclk, drives sclk and exposes the fall tick.
module tdm_clkgen
  import i2s_tdm_pkg::*;
#(
  parameter int unsigned G_SCLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic sclk,
  output logic fall_c
);

  localparam int unsigned CW = cnt_width(G_SCLK_DIV);

  logic [CW-1:0] cnt;
  logic          rise_c;

  assign rise_c = (cnt == CW'(G_SCLK_DIV / 2 - 1));
  assign fall_c = (cnt == CW'(G_SCLK_DIV - 1));

  // Divider counter and 50% duty bit clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else begin
      cnt <= fall_c ? '0 : cnt + CW'(1);
      if (rise_c) begin
        sclk <= 1'b1;
      end else if (fall_c) begin
        sclk <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/tdm_tx.sv
// TDM serializer: double-buffers strobed sample frames and shifts them out
// MSB-first, one slot per channel, with underrun/overrun flags.
module tdm_tx
  import i2s_tdm_pkg::*;
#(
  parameter int unsigned G_BITS      = DEF_BITS,
  parameter int unsigned G_SLOTS     = 8,
  parameter int unsigned G_SLOT_BITS = 32,
  parameter int unsigned G_SCLK_DIV  = 4
) (
  input  logic                        in_mclk,
  input  logic                        in_rst,
  input  logic [G_SLOTS*G_BITS-1:0]   in_frame,
  input  logic                        in_frame_strobe,
  output logic                        out_sclk,
  output logic                        out_fsync,
  output logic                        out_dout,
  output logic                        out_load,
  output logic                        out_underrun,
  output logic                        out_overrun
);

  localparam int unsigned FW = G_SLOTS * G_BITS;
  localparam int unsigned SW = cnt_width(G_SLOTS);
  localparam int unsigned BW = cnt_width(G_SLOT_BITS);
  localparam int unsigned IW = cnt_width(G_BITS);

  typedef struct packed {
    logic [SW-1:0] slot;
    logic [BW-1:0] bit_idx;
  } pos_t;

  pos_t              pos;
  pos_t              pos_next;
  logic [FW-1:0]     pending;
  logic [FW-1:0]     active;
  logic [FW-1:0]     frame_src;
  logic              pending_valid;
  logic              fall_c;
  logic              boundary_c;
  logic [G_BITS-1:0] slot_word [G_SLOTS];
  logic [G_BITS-1:0] cur_word;
  logic [IW-1:0]     idx;
  logic              in_data;
  logic              data_bit;

  tdm_clkgen #(
    .G_SCLK_DIV(G_SCLK_DIV)
  ) u_clkgen (
    .clk    (in_mclk),
    .rst    (in_rst),
    .sclk   (out_sclk),
    .fall_c (fall_c)
  );

  assign boundary_c = fall_c && (pos == '0);

  // Next (slot, bit) position, bit first, then slot, wrapping at frame end
  always_comb begin
    pos_next = pos;
    if (pos.bit_idx == BW'(G_SLOT_BITS - 1)) begin
      pos_next.bit_idx = '0;
      pos_next.slot    = (pos.slot == SW'(G_SLOTS - 1)) ? '0 : pos.slot + SW'(1);
    end else begin
      pos_next.bit_idx = pos.bit_idx + BW'(1);
    end
  end

  // At a loading boundary the new frame is serialized immediately
  always_comb begin
    frame_src = (boundary_c && pending_valid) ? pending : active;
    for (int k = 0; k < G_SLOTS; k++) begin
      slot_word[k] = frame_src[k*G_BITS +: G_BITS];
    end
  end

  assign cur_word = slot_word[pos.slot];

  // Left-justified MSB-first bit select; padding bits are zero
  always_comb begin
    idx      = IW'(G_BITS - 1) - IW'(pos.bit_idx);
    in_data  = ({1'b0, pos.bit_idx} < (BW + 1)'(G_BITS));
    data_bit = in_data ? cur_word[idx] : 1'b0;
  end

  // Position counters and serial outputs, all moving on fall ticks
  always_ff @(posedge in_mclk or posedge in_rst) begin
    if (in_rst) begin
      pos       <= '0;
      out_fsync <= 1'b0;
      out_dout  <= 1'b0;
    end else if (fall_c) begin
      pos       <= pos_next;
      out_fsync <= (pos == '0);
      out_dout  <= data_bit;
    end
  end

  // Frame buffers and rate-mismatch pulses; boundary sees pre-strobe state
  always_ff @(posedge in_mclk or posedge in_rst) begin
    if (in_rst) begin
      pending       <= '0;
      active        <= '0;
      pending_valid <= 1'b0;
      out_load      <= 1'b0;
      out_underrun  <= 1'b0;
      out_overrun   <= 1'b0;
    end else begin
      out_load     <= boundary_c && pending_valid;
      out_underrun <= boundary_c && !pending_valid;
      out_overrun  <= in_frame_strobe && pending_valid && !boundary_c;
      if (boundary_c && pending_valid) begin
        active <= pending;
      end
      if (in_frame_strobe) begin
        pending       <= in_frame;
        pending_valid <= 1'b1;
      end else if (boundary_c) begin
        pending_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tdm_tx.sv
// Randomized scoreboard bench for tdm_tx: an event-level model predicts
// frame contents and flag pulses; a monitor deserializes the bus and compares.
module tb_tdm_tx;
  import i2s_tdm_pkg::frame_cycles;

  localparam int unsigned NB    = 16;
  localparam int unsigned NS    = 4;
  localparam int unsigned SB    = 32;
  localparam int unsigned DIV   = 4;
  localparam int          FRAME = int'(frame_cycles(NS, SB, DIV));
  localparam int          FIRST = int'(DIV);
  localparam int          NBITS = int'(NS * SB);

  typedef struct {
    int at_edge;
    int kind;   // 0 load, 1 underrun, 2 overrun
  } ev_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [63:0]   in_frame = '0;
  logic          in_frame_strobe = 1'b0;
  logic          out_sclk, out_fsync, out_dout, out_load, out_underrun, out_overrun;

  int            cyc;
  int            n_checks = 0;
  int            n_err = 0;

  ev_t           ev_q[$];
  logic [63:0]   frame_q[$];

  tdm_tx #(
    .G_BITS(NB), .G_SLOTS(NS), .G_SLOT_BITS(SB), .G_SCLK_DIV(DIV)
  ) dut (
    .in_mclk         (clk),
    .in_rst          (rst),
    .in_frame        (in_frame),
    .in_frame_strobe (in_frame_strobe),
    .out_sclk        (out_sclk),
    .out_fsync       (out_fsync),
    .out_dout        (out_dout),
    .out_load        (out_load),
    .out_underrun    (out_underrun),
    .out_overrun     (out_overrun)
  );

  always #5 clk = ~clk;

  // Edge number since reset release (value n after the n-th rising edge)
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  // Serial bit stream a frame should produce: slot k bit b (b<NB) is sample MSB-first
  function automatic logic [127:0] expected_stream(input logic [63:0] f);
    logic [127:0] s;
    logic [15:0]  w;
    s = '0;
    for (int k = 0; k < int'(NS); k++) begin
      w = f[k*16 +: 16];
      for (int b = 0; b < int'(NB); b++) s[k*int'(SB) + b] = w[15-b];
    end
    return s;
  endfunction

  function automatic int after_boundary(input int e);
    return FIRST + FRAME * ((e - FIRST) / FRAME + 1);
  endfunction

  function automatic int at_or_after_boundary(input int e);
    return FIRST + FRAME * ((e - FIRST + FRAME - 1) / FRAME);
  endfunction

  // Reference model: frames switch at boundary edges; strobes queue one frame
  initial begin : model
    logic [63:0] m_pending, m_active;
    logic        m_pv;
    int          n;
    m_pending = '0; m_active = '0; m_pv = 1'b0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_pending = '0; m_active = '0; m_pv = 1'b0;
        ev_q.delete();
        frame_q.delete();
      end else begin
        n = cyc + 1;
        if (n >= FIRST && ((n - FIRST) % FRAME) == 0) begin
          if (m_pv) begin
            m_active = m_pending;
            m_pv = 1'b0;
            ev_q.push_back('{n, 0});
          end else begin
            ev_q.push_back('{n, 1});
          end
          frame_q.push_back(m_active);
        end
        if (in_frame_strobe) begin
          if (m_pv) ev_q.push_back('{n, 2});
          m_pending = in_frame;
          m_pv = 1'b1;
        end
      end
    end
  end

  task automatic pop_pulse(input int kind);
    ev_t e;
    if (ev_q.size() == 0) begin
      n_checks++;
      n_err++;
      $display("FAIL pulse kind %0d at cycle %0d: got a pulse, expected none", kind, cyc);
    end else begin
      e = ev_q.pop_front();
      check("pulse_kind", 128'(kind), 128'(e.kind));
      check("pulse_cycle", 128'(cyc), 128'(e.at_edge));
    end
  endtask

  // Monitor: receiver samples on sclk rise; flags checked every mclk cycle
  initial begin : monitor
    logic         prev_sclk, collecting;
    logic [127:0] rx;
    int           bitcnt, fsync_bad;
    prev_sclk = 1'b0; collecting = 1'b0; rx = '0; bitcnt = 0; fsync_bad = 0;
    forever begin
      @(negedge clk or posedge rst);
      if (rst) begin
        prev_sclk = 1'b0; collecting = 1'b0; bitcnt = 0; fsync_bad = 0;
      end else begin
        if (out_sclk && !prev_sclk) begin
          if (!collecting && out_fsync) begin
            collecting = 1'b1;
            bitcnt = 0;
            rx = '0;
          end
          if (collecting) begin
            if (out_fsync != (bitcnt == 0)) fsync_bad++;
            rx[bitcnt] = out_dout;
            bitcnt++;
            if (bitcnt == NBITS) begin
              collecting = 1'b0;
              if (frame_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL frame_bits at cycle %0d: got frame %0h, expected none", cyc, rx);
              end else begin
                check("frame_bits", rx, expected_stream(frame_q.pop_front()));
              end
              check("fsync_position", 128'(fsync_bad), 128'(0));
              fsync_bad = 0;
            end
          end
        end
        prev_sclk = out_sclk;
        if (out_load)     pop_pulse(0);
        if (out_underrun) pop_pulse(1);
        if (out_overrun)  pop_pulse(2);
      end
    end
  end

  task automatic goto(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic strobe_at(input int e, input logic [63:0] f);
    goto(e - 1);
    in_frame = f;
    in_frame_strobe = 1'b1;
    @(negedge clk);
    in_frame_strobe = 1'b0;
  endtask

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int e, b;
    repeat (3) @(negedge clk);
    check("reset_outputs", 128'({out_sclk, out_fsync, out_dout, out_load, out_underrun, out_overrun}), 128'(0));
    rst = 1'b0;

    // Startup timing
    goto(1); check("sclk_c1", 128'(out_sclk), 128'(0));
    goto(2); check("sclk_first_rise", 128'(out_sclk), 128'(1));
    goto(3); check("fsync_c3", 128'(out_fsync), 128'(0));
    goto(4); check("sclk_first_fall", 128'(out_sclk), 128'(0));
             check("fsync_c4", 128'(out_fsync), 128'(1));
             check("dout_c4", 128'(out_dout), 128'(0));
    goto(7); check("fsync_c7", 128'(out_fsync), 128'(1));
    goto(8); check("fsync_c8", 128'(out_fsync), 128'(0));

    // Known frame before the second boundary
    strobe_at(100, {16'h8001, 16'hA5A5, 16'h00FF, 16'hF00F});
    // Strobes landing exactly on boundary ticks
    strobe_at(FIRST + 2*FRAME, 64'h0123_4567_89AB_CDEF);
    strobe_at(FIRST + 3*FRAME, 64'hFEDC_BA98_7654_3210);
    // Two strobes within one frame: overrun, newer wins
    strobe_at(FIRST + 4*FRAME + 48, {4{16'h1111}});
    strobe_at(FIRST + 4*FRAME + 300, {4{16'h2222}});
    // One frame with no strobe: repeat and underrun
    e = FIRST + 6*FRAME + 10;
    goto(e);

    // Randomized strobe spacing, sometimes snapped to a boundary tick
    repeat (8) begin
      e += int'($urandom_range(60, 900));
      if ($urandom_range(0, 3) == 0) e = at_or_after_boundary(e);
      strobe_at(e, {$urandom, $urandom});
    end

    // Frame with slot 2 all ones, then reset in the middle of slot 2
    e += int'($urandom_range(50, 400));
    strobe_at(e, {16'h1234, 16'hFFFF, 16'h0F0F, 16'hC3C3});
    b = after_boundary(e);
    goto(b + 4*(2*int'(SB) + 5) + 2);
    check("pre_reset_sclk", 128'(out_sclk), 128'(1));
    check("pre_reset_dout", 128'(out_dout), 128'(1));
    check("pre_reset_pulses_pending", 128'(ev_q.size()), 128'(0));
    check("pre_reset_frames_pending", 128'(frame_q.size()), 128'(1));
    rst = 1'b1;
    #1;
    check("async_reset_outputs", 128'({out_sclk, out_fsync, out_dout, out_load, out_underrun, out_overrun}), 128'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Restart from slot 0 bit 0 with zero data
    goto(3); check("restart_fsync_c3", 128'(out_fsync), 128'(0));
    goto(4); check("restart_fsync_c4", 128'(out_fsync), 128'(1));
             check("restart_dout_c4", 128'(out_dout), 128'(0));
    goto(FIRST + FRAME + 4);
    check("end_pulses_pending", 128'(ev_q.size()), 128'(0));
    check("end_frames_pending", 128'(frame_q.size()), 128'(1));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
